sha256_block_sequencer: RTL and testbench
=========================================

# sha256_block_sequencer

Controller that sequences the SHA256_core command/address protocol on behalf of a streaming host. It accepts 512-bit message blocks as 16 beats of 32-bit words and drives the core through init, schedule load, compute wait and digest readout. After the final block it returns the 256-bit digest as an 8-beat stream. It sits between the bus/DMA front end and the core, and is the only agent driving the core's a_in/d_in.

## Interface
- TIMEOUT_CYCLES, 255: maximum cycles allowed from the end-load command to status[0]=1 before a timeout is declared (16-bit counter).
- clk_in  in  1  clock; shared with the core.
- rst_in  in  1  reset, asynchronous, active-low; the same net also resets the core.
- msg_valid  in  1  host word valid.
- msg_ready  out  1  host word accepted when msg_valid&msg_ready.
- msg_word  in  32  message word; big-endian schedule word W[i].
- msg_sof  in  1  start of message; sampled only on the first beat taken in S_IDLE.
- msg_eom  in  1  last block of message; sampled only on beat 15 of a block.
- dig_valid  out  1  digest word valid.
- dig_ready  in  1  digest word accepted.
- dig_word  out  32  digest word; H0 first.
- dig_last  out  1  high on digest word 7.
- busy  out  1  state != S_IDLE.
- err_timeout  out  1  sticky; set on timeout, cleared on the next accepted msg_sof.
- core_a_out  out  32  to core a_in; [31:29] command, [5:0] word index.
- core_d_out  out  32  to core d_in.
- core_d_in  in  32  from core d_out.
- core_status_in  in  32  from core status; only bit 0 is used.

## Operation
- Core commands, carried in a_in[31:29]:
  - 111: wipe to WAIT.
  - 001: load IV, go to IDLE.
  - 010: enter load.
  - During load, any command other than 100 writes schedule[a_in[5:0]] <= d_in every cycle.
  - 100: end load and start compute.
  - 011: enter readout. In readout, d_out <= hash[a_in[2:0]] every cycle, and command 000 exits.
- All outputs are registered. Reset values are 0: core_a_out, core_d_out, msg_ready, dig_valid, dig_word, dig_last, busy, err_timeout. State resets to S_IDLE.
- States:
  - S_IDLE: msg_ready=0. If msg_valid&msg_sof, go to S_WIPE (the beat is not consumed). If msg_valid&!msg_sof, pulse msg_ready for 1 cycle to drop the word and stay in S_IDLE.
  - S_WIPE: core_a_out=111<<29 for 1 cycle, then S_INIT.
  - S_INIT: core_a_out=001<<29 for 1 cycle, then S_LDCMD. Clear err_timeout.
  - S_LDCMD: 010<<29 for 1 cycle, then S_LOAD with idx=0.
  - S_LOAD: msg_ready=1.
    - On each beat: core_a_out={3'b000,23'b0,idx}, core_d_out=msg_word, idx++, and latch msg_eom when idx==15.
    - When a beat is not taken, outputs hold. The core then rewrites the same index with the same value, which is harmless.
    - After beat 15, go to S_LDEND.
  - S_LDEND: 100<<29 for 1 cycle; clear the timeout counter, then S_WAIT.
  - S_WAIT: core_a_out=0. When core_status_in[0]=1:
    - eom latched: go to S_RDCMD.
    - otherwise: go to S_LDCMD for the next block; the chaining value stays in the core.
    - If the counter reaches TIMEOUT_CYCLES first: set err_timeout and go to S_WIPE_ERR.
  - S_WIPE_ERR: 111<<29 for 1 cycle, then S_IDLE.
  - S_RDCMD: 011<<29 for 1 cycle, then S_RD.
  - S_RD:
    - Issue core_a_out={3'b011,26'b0,rdaddr[2:0]} for rdaddr=0..7 on 8 consecutive cycles, then 2 drain cycles holding address 7.
    - Capture core_d_in into digest buffer slot j exactly 2 cycles after address j is driven.
    - After the 10th cycle, go to S_RDEND.
  - S_RDEND: 000<<29 for 1 cycle (core returns to IDLE), then S_OUT.
  - S_OUT: present buffer words 0..7 with valid/ready; dig_last on word 7. After the word-7 handshake, go to S_IDLE.
- Stale status: status[0] stays 1 until the core sees 010/011/111. S_WAIT is only entered after 010 has been issued, so the stale value is never sampled.

## Timing
- Message start: 2 command cycles (S_WIPE, S_INIT). Per block: 1 (LDCMD) + 16 beats minimum + 1 (LDEND) + core compute (~180 cycles).
- Readout: 1 + 10 + 1 cycles, then 8 output beats at a minimum of 1 per cycle.
- Readout uses a fixed 2-cycle address-to-data latency: controller output register, then core d_out register.
- Valid/ready: dig_valid, dig_word and dig_last are held stable until dig_ready; msg_ready does not depend combinationally on msg_valid.
- Reset mid-operation returns both the controller and the core to their reset states. No digest is emitted and err_timeout=0.

## Test plan
- "abc" single block: words 61626380, 14×00000000, 00000018, eom=1 → digest ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad; dig_last on beat 8.
- Empty message: 80000000 then 15 zeros, eom=1 → e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855.
- NIST 448-bit two-block "abcdbcde…nopq" (eom on block 2 only), with msg_valid randomly deasserted 50% → 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1; no 111 between blocks.
- Two back-to-back "abc" messages with dig_ready held low for 20 cycles → identical digests; dig_word stable while stalled; the second message issues 111 then 001.
- Core stub with status stuck at 0 → err_timeout rises exactly TIMEOUT_CYCLES cycles after 100; 111 follows; busy=0; the next sof clears err_timeout.
- Word without sof in S_IDLE → dropped, no core command issued. rst_in low after load beat 7 → all outputs 0; a subsequent "abc" gives the correct digest.

Source files
------------

// File: rtl/sha256_block_sequencer.sv
// sha256_block_sequencer
//
// Drives the SHA256 core's command/address bus for a streaming host. The host
// sends 512-bit blocks as 16 big-endian 32-bit words. The controller brackets
// them with the core's wipe / IV / load / end-load commands and waits for the
// core to finish. After the block flagged end-of-message it reads the eight
// hash words back and streams them out.
//
// Ports
//   clk_in, rst_in       clock, asynchronous active-low reset (shared with core)
//   msg_valid/ready      host word handshake; msg_word = W[i], msg_sof, msg_eom
//   dig_valid/ready      digest word handshake; dig_word (H0 first), dig_last
//   busy                 controller not idle
//   err_timeout          sticky; core did not finish within TIMEOUT_CYCLES
//   core_a_out           core a_in: [31:29] command, [5:0] word index
//   core_d_out           core d_in
//   core_d_in            core d_out
//   core_status_in       core status, bit 0 = compute done
//
// Every output is a register. The next value of each output is computed from
// the current state, so a command chosen in state X shows up on core_a_out in
// the cycle after X.
module sha256_block_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        msg_valid,
  output logic        msg_ready,
  input  logic [31:0] msg_word,
  input  logic        msg_sof,
  input  logic        msg_eom,
  output logic        dig_valid,
  input  logic        dig_ready,
  output logic [31:0] dig_word,
  output logic        dig_last,
  output logic        busy,
  output logic        err_timeout,
  output logic [31:0] core_a_out,
  output logic [31:0] core_d_out,
  input  logic [31:0] core_d_in,
  input  logic [31:0] core_status_in
);

  localparam logic [2:0]  CMD_WR   = 3'b000;
  localparam logic [2:0]  CMD_INIT = 3'b001;
  localparam logic [2:0]  CMD_LOAD = 3'b010;
  localparam logic [2:0]  CMD_READ = 3'b011;
  localparam logic [2:0]  CMD_END  = 3'b100;
  localparam logic [2:0]  CMD_WIPE = 3'b111;
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_WIPE, S_INIT, S_LDCMD, S_LOAD, S_LDEND, S_WAIT,
    S_WIPE_ERR, S_RDCMD, S_RD, S_RDEND, S_OUT
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic        eom_q, eom_d;
  logic [15:0] tmo_q, tmo_d;
  logic [3:0]  rd_q, rd_d;
  logic [2:0]  oidx_q, oidx_d;
  logic [31:0] buf_q [8];

  logic [31:0] core_a_q, core_a_d;
  logic [31:0] core_d_q, core_d_d;
  logic        msg_ready_q, msg_ready_d;
  logic        dig_valid_q, dig_valid_d;
  logic [31:0] dig_word_q, dig_word_d;
  logic        dig_last_q, dig_last_d;
  logic        busy_q, busy_d;
  logic        err_q, err_d;

  logic [2:0]  cap_slot;
  logic [2:0]  rd_addr;
  logic        unused_status_bits;

  // Data driven by core_a in readout reaches core_d_in two cycles later, so
  // the slot being written trails the read counter by two.
  assign cap_slot = rd_q[2:0] - 3'd2;
  // Counts 8 and 9 are drain cycles that keep the last address on the bus.
  assign rd_addr  = (rd_q >= 4'd7) ? 3'd7 : rd_q[2:0];
  assign unused_status_bits = ^core_status_in[31:1];

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    eom_d       = eom_q;
    tmo_d       = tmo_q;
    rd_d        = rd_q;
    oidx_d      = oidx_q;
    core_a_d    = core_a_q;
    core_d_d    = core_d_q;
    msg_ready_d = 1'b0;
    dig_valid_d = dig_valid_q;
    dig_word_d  = dig_word_q;
    dig_last_d  = dig_last_q;
    err_d       = err_q;

    case (state_q)
      S_IDLE: begin
        core_a_d = '0;
        // The ready pulse of a dropped word must not be mistaken for a new
        // start, hence the msg_ready_q guard.
        if (msg_valid && !msg_ready_q) begin
          if (msg_sof) state_d = S_WIPE;
          else         msg_ready_d = 1'b1;
        end
      end
      S_WIPE: begin
        core_a_d = {CMD_WIPE, 29'd0};
        state_d  = S_INIT;
      end
      S_INIT: begin
        core_a_d = {CMD_INIT, 29'd0};
        err_d    = 1'b0;
        state_d  = S_LDCMD;
      end
      S_LDCMD: begin
        core_a_d    = {CMD_LOAD, 29'd0};
        idx_d       = '0;
        msg_ready_d = 1'b1;
        state_d     = S_LOAD;
      end
      S_LOAD: begin
        msg_ready_d = 1'b1;
        if (msg_valid && msg_ready_q) begin
          core_a_d = {CMD_WR, 23'd0, 2'd0, idx_q};
          core_d_d = msg_word;
          idx_d    = idx_q + 4'd1;
          if (idx_q == 4'd15) begin
            eom_d       = msg_eom;
            msg_ready_d = 1'b0;
            state_d     = S_LDEND;
          end
        end
      end
      S_LDEND: begin
        core_a_d = {CMD_END, 29'd0};
        tmo_d    = '0;
        state_d  = S_WAIT;
      end
      S_WAIT: begin
        core_a_d = '0;
        tmo_d    = tmo_q + 16'd1;
        if (core_status_in[0]) begin
          state_d = eom_q ? S_RDCMD : S_LDCMD;
        end else if (tmo_q == TMO_LAST) begin
          err_d   = 1'b1;
          state_d = S_WIPE_ERR;
        end
      end
      S_WIPE_ERR: begin
        core_a_d = {CMD_WIPE, 29'd0};
        state_d  = S_IDLE;
      end
      S_RDCMD: begin
        core_a_d = {CMD_READ, 29'd0};
        rd_d     = '0;
        state_d  = S_RD;
      end
      S_RD: begin
        core_a_d = {CMD_READ, 26'd0, rd_addr};
        rd_d     = rd_q + 4'd1;
        if (rd_q == 4'd9) state_d = S_RDEND;
      end
      S_RDEND: begin
        core_a_d    = {CMD_WR, 29'd0};
        dig_valid_d = 1'b1;
        dig_word_d  = buf_q[0];
        dig_last_d  = 1'b0;
        oidx_d      = '0;
        state_d     = S_OUT;
      end
      S_OUT: begin
        if (dig_valid_q && dig_ready) begin
          if (oidx_q == 3'd7) begin
            dig_valid_d = 1'b0;
            dig_last_d  = 1'b0;
            state_d     = S_IDLE;
          end else begin
            oidx_d     = oidx_q + 3'd1;
            dig_word_d = buf_q[oidx_q + 3'd1];
            dig_last_d = (oidx_q == 3'd6);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      eom_q       <= 1'b0;
      tmo_q       <= '0;
      rd_q        <= '0;
      oidx_q      <= '0;
      core_a_q    <= '0;
      core_d_q    <= '0;
      msg_ready_q <= 1'b0;
      dig_valid_q <= 1'b0;
      dig_word_q  <= '0;
      dig_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      eom_q       <= eom_d;
      tmo_q       <= tmo_d;
      rd_q        <= rd_d;
      oidx_q      <= oidx_d;
      core_a_q    <= core_a_d;
      core_d_q    <= core_d_d;
      msg_ready_q <= msg_ready_d;
      dig_valid_q <= dig_valid_d;
      dig_word_q  <= dig_word_d;
      dig_last_q  <= dig_last_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
    end
  end

  // Digest buffer holds data only and needs no reset.
  always_ff @(posedge clk_in) begin
    if (state_q == S_RD && rd_q >= 4'd2) buf_q[cap_slot] <= core_d_in;
  end

  assign core_a_out  = core_a_q;
  assign core_d_out  = core_d_q;
  assign msg_ready   = msg_ready_q;
  assign dig_valid   = dig_valid_q;
  assign dig_word    = dig_word_q;
  assign dig_last    = dig_last_q;
  assign busy        = busy_q;
  assign err_timeout = err_q;

endmodule

// File: tb/tb_sha256_block_sequencer.sv
module tb_sha256_block_sequencer;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic        msg_valid = 1'b0;
  logic        msg_ready;
  logic [31:0] msg_word = '0;
  logic        msg_sof = 1'b0;
  logic        msg_eom = 1'b0;
  logic        dig_valid;
  logic        dig_ready = 1'b0;
  logic [31:0] dig_word;
  logic        dig_last;
  logic        busy;
  logic        err_timeout;
  logic [31:0] core_a_out;
  logic [31:0] core_d_out;
  logic [31:0] core_d_in;
  logic [31:0] core_status_in;

  int n_tests = 0;
  int n_fail  = 0;

  sha256_block_sequencer #(.TIMEOUT_CYCLES(255)) dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .msg_valid(msg_valid), .msg_ready(msg_ready), .msg_word(msg_word),
    .msg_sof(msg_sof), .msg_eom(msg_eom),
    .dig_valid(dig_valid), .dig_ready(dig_ready), .dig_word(dig_word), .dig_last(dig_last),
    .busy(busy), .err_timeout(err_timeout),
    .core_a_out(core_a_out), .core_d_out(core_d_out),
    .core_d_in(core_d_in), .core_status_in(core_status_in)
  );

  always #5 clk_in = ~clk_in;

  localparam logic [511:0] ABC   = {32'h61626380, 448'd0, 32'h00000018};
  localparam logic [511:0] EMPTY = {32'h80000000, 480'd0};
  localparam logic [511:0] NIST1 = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                    32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                    32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                    32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] NIST2 = {480'd0, 32'h000001c0};
  localparam logic [255:0] DG_ABC   = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [255:0] DG_EMPTY = 256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
  localparam logic [255:0] DG_NIST  = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;
  localparam logic [255:0] IV = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] sha_compress(input logic [255:0] hin, input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2, s0, s1;
    for (int i = 0; i < 16; i++) w[i] = blk[511 - 32*i -: 32];
    for (int i = 16; i < 64; i++) begin
      s0 = ror(w[i-15], 7) ^ ror(w[i-15], 18) ^ (w[i-15] >> 3);
      s1 = ror(w[i-2], 17) ^ ror(w[i-2], 19) ^ (w[i-2] >> 10);
      w[i] = w[i-16] + s0 + w[i-7] + s1;
    end
    {a, b, c, d, e, f, g, h} = hin;
    for (int i = 0; i < 64; i++) begin
      s1 = ror(e, 6) ^ ror(e, 11) ^ ror(e, 25);
      t1 = h + s1 + ((e & f) ^ (~e & g)) + K[i] + w[i];
      s0 = ror(a, 2) ^ ror(a, 13) ^ ror(a, 22);
      t2 = s0 + ((a & b) ^ (a & c) ^ (b & c));
      h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
    end
    return {hin[255:224] + a, hin[223:192] + b, hin[191:160] + c, hin[159:128] + d,
            hin[127:96] + e, hin[95:64] + f, hin[63:32] + g, hin[31:0] + h};
  endfunction

  // Behavioural SHA256 core: command protocol plus real compression.
  typedef enum logic [2:0] {C_WAIT, C_IDLE, C_LOAD, C_COMP, C_READ} cst_t;
  localparam int COMP_LAT = 70;
  cst_t         cst;
  logic [255:0] chash;
  logic [511:0] csched;
  logic         cstat;
  logic [31:0]  cdout;
  int           ccnt;
  logic         stuck = 1'b0;
  logic [2:0]   ccmd;

  assign ccmd           = core_a_out[31:29];
  assign core_d_in      = cdout;
  assign core_status_in = {31'd0, cstat & ~stuck};

  always @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      cst <= C_WAIT; chash <= '0; csched <= '0; cstat <= 1'b0; cdout <= '0; ccnt <= 0;
    end else if (ccmd == 3'b111) begin
      cst <= C_WAIT; chash <= '0; cstat <= 1'b0;
    end else begin
      case (cst)
        C_WAIT, C_IDLE: begin
          if (ccmd == 3'b001) begin chash <= IV; cst <= C_IDLE; end
          else if (ccmd == 3'b010) begin cst <= C_LOAD; cstat <= 1'b0; end
          else if (ccmd == 3'b011) begin cst <= C_READ; cstat <= 1'b0; end
        end
        C_LOAD: begin
          if (ccmd == 3'b100) begin cst <= C_COMP; ccnt <= COMP_LAT; end
          else csched[511 - 32*int'(core_a_out[3:0]) -: 32] <= core_d_out;
        end
        C_COMP: begin
          if (ccnt == 0) begin
            if (!stuck) begin chash <= sha_compress(chash, csched); cstat <= 1'b1; cst <= C_IDLE; end
          end else ccnt <= ccnt - 1;
        end
        C_READ: begin
          if (ccmd == 3'b000) cst <= C_IDLE;
          else cdout <= chash[255 - 32*int'(core_a_out[2:0]) -: 32];
        end
        default: cst <= C_WAIT;
      endcase
    end
  end

  // Bus monitor
  int cyc = 0;
  int n_wipe = 0, n_init = 0, n_end = 0, n_achg = 0;
  int cyc_wipe = 0, cyc_init = 0, cyc_end = 0, cyc_err = 0;
  logic [31:0] prev_a = '0;
  logic prev_err = 1'b0;

  always @(posedge clk_in) cyc <= cyc + 1;

  always @(negedge clk_in) begin
    if (ccmd == 3'b111) begin n_wipe <= n_wipe + 1; cyc_wipe <= cyc; end
    if (ccmd == 3'b001) begin n_init <= n_init + 1; cyc_init <= cyc; end
    if (ccmd == 3'b100) begin n_end  <= n_end + 1;  cyc_end  <= cyc; end
    if (core_a_out !== prev_a) n_achg <= n_achg + 1;
    prev_a <= core_a_out;
    if (err_timeout && !prev_err) cyc_err <= cyc;
    prev_err <= err_timeout;
  end

  task automatic send_block(input logic [511:0] b, input bit sof, input bit eom,
                            input bit gaps, input int nbeats, output bit ok);
    int waitc;
    ok = 1'b1;
    for (int i = 0; i < nbeats; i++) begin
      if (gaps && ($urandom_range(0, 1) == 0)) begin
        msg_valid = 1'b0;
        @(negedge clk_in);
      end
      msg_valid = 1'b1;
      msg_word  = b[511 - 32*i -: 32];
      msg_sof   = sof && (i == 0);
      msg_eom   = eom && (i == 15);
      waitc = 0;
      while (!msg_ready && waitc < 1000) begin @(negedge clk_in); waitc++; end
      if (!msg_ready) begin ok = 1'b0; break; end
      @(negedge clk_in);
    end
    msg_valid = 1'b0; msg_sof = 1'b0; msg_eom = 1'b0;
  endtask

  task automatic collect_digest(input int stall, output logic [255:0] dg, output logic [7:0] lmask,
                                output bit ok, output bit stable);
    int waitc, k;
    logic [31:0] held;
    dg = '0; lmask = '0; ok = 1'b1; stable = 1'b1; k = 0; waitc = 0;
    dig_ready = 1'b0;
    while (!dig_valid && waitc < 2000) begin @(negedge clk_in); waitc++; end
    if (!dig_valid) begin ok = 1'b0; return; end
    held = dig_word;
    for (int s = 0; s < stall; s++) begin
      @(negedge clk_in);
      if (!dig_valid || dig_word !== held) stable = 1'b0;
    end
    dig_ready = 1'b1;
    while (k < 8 && waitc < 2000) begin
      if (dig_valid) begin
        dg[255 - 32*k -: 32] = dig_word;
        lmask[k] = dig_last;
        k++;
      end
      @(negedge clk_in);
      waitc++;
    end
    dig_ready = 1'b0;
    if (k < 8) ok = 1'b0;
  endtask

  task automatic test_reset();
    rst_in = 1'b0;
    repeat (3) @(negedge clk_in);
    n_tests++;
    if ({msg_ready, dig_valid, dig_last, busy, err_timeout} !== 5'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b exp 00000", {msg_ready, dig_valid, dig_last, busy, err_timeout});
    end
    n_tests++;
    if (core_a_out !== 32'h0 || core_d_out !== 32'h0) begin
      n_fail++; $display("FAIL reset_core_bus: got a=%h d=%h exp 0", core_a_out, core_d_out);
    end
    n_tests++;
    if (dig_word !== 32'h0) begin n_fail++; $display("FAIL reset_dig_word: got %h exp 0", dig_word); end
    rst_in = 1'b1;
    @(negedge clk_in);
  endtask

  task automatic test_abc();
    logic [255:0] dg; logic [7:0] lm; bit ok, st;
    send_block(ABC, 1'b1, 1'b1, 1'b0, 16, ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL abc_send: got stalled beat exp all 16 accepted"); end
    collect_digest(0, dg, lm, ok, st);
    n_tests++;
    if (!ok || dg !== DG_ABC) begin n_fail++; $display("FAIL abc_digest: got %h exp %h", dg, DG_ABC); end
    n_tests++;
    if (lm !== 8'h80) begin n_fail++; $display("FAIL abc_last: got mask %b exp 10000000", lm); end
    n_tests++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL abc_busy_after: got %b exp 0", busy); end
  endtask

  task automatic test_empty();
    logic [255:0] dg; logic [7:0] lm; bit ok, st;
    send_block(EMPTY, 1'b1, 1'b1, 1'b0, 16, ok);
    collect_digest(0, dg, lm, ok, st);
    n_tests++;
    if (!ok || dg !== DG_EMPTY) begin n_fail++; $display("FAIL empty_digest: got %h exp %h", dg, DG_EMPTY); end
  endtask

  task automatic test_two_block_gaps();
    logic [255:0] dg; logic [7:0] lm; bit ok1, ok2, ok, st;
    int w0, e0;
    w0 = n_wipe; e0 = n_end;
    send_block(NIST1, 1'b1, 1'b0, 1'b1, 16, ok1);
    send_block(NIST2, 1'b0, 1'b1, 1'b1, 16, ok2);
    collect_digest(0, dg, lm, ok, st);
    n_tests++;
    if (!ok1 || !ok2 || !ok || dg !== DG_NIST) begin
      n_fail++; $display("FAIL nist_digest: got %h exp %h", dg, DG_NIST);
    end
    n_tests++;
    if (n_wipe - w0 != 1) begin n_fail++; $display("FAIL nist_wipes: got %0d exp 1", n_wipe - w0); end
    n_tests++;
    if (n_end - e0 != 2) begin n_fail++; $display("FAIL nist_endloads: got %0d exp 2", n_end - e0); end
  endtask

  task automatic test_back_to_back();
    logic [255:0] dg1, dg2; logic [7:0] lm; bit ok, st, ok2, st2;
    int w0;
    send_block(ABC, 1'b1, 1'b1, 1'b0, 16, ok);
    collect_digest(20, dg1, lm, ok, st);
    n_tests++;
    if (!ok || dg1 !== DG_ABC) begin n_fail++; $display("FAIL b2b_digest1: got %h exp %h", dg1, DG_ABC); end
    n_tests++;
    if (!st) begin n_fail++; $display("FAIL b2b_stall_stable: got unstable dig_word exp stable"); end
    w0 = n_wipe;
    send_block(ABC, 1'b1, 1'b1, 1'b0, 16, ok2);
    n_tests++;
    if (n_wipe - w0 != 1 || cyc_init != cyc_wipe + 1) begin
      n_fail++; $display("FAIL b2b_wipe_init: got wipes=%0d init-wipe=%0d exp 1 and 1", n_wipe - w0, cyc_init - cyc_wipe);
    end
    collect_digest(0, dg2, lm, ok2, st2);
    n_tests++;
    if (!ok2 || dg2 !== DG_ABC) begin n_fail++; $display("FAIL b2b_digest2: got %h exp %h", dg2, DG_ABC); end
  endtask

  task automatic test_timeout();
    logic [255:0] dg; logic [7:0] lm; bit ok, st;
    int waitc;
    stuck = 1'b1;
    send_block(ABC, 1'b1, 1'b1, 1'b0, 16, ok);
    waitc = 0;
    while (!err_timeout && waitc < 600) begin @(negedge clk_in); waitc++; end
    repeat (2) @(negedge clk_in);
    n_tests++;
    if (!err_timeout) begin n_fail++; $display("FAIL tmo_flag: got 0 exp 1"); end
    n_tests++;
    if (cyc_err - cyc_end != 255) begin n_fail++; $display("FAIL tmo_latency: got %0d exp 255", cyc_err - cyc_end); end
    n_tests++;
    if (cyc_wipe != cyc_err + 1) begin n_fail++; $display("FAIL tmo_wipe: got wipe-err=%0d exp 1", cyc_wipe - cyc_err); end
    n_tests++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL tmo_busy: got %b exp 0", busy); end
    stuck = 1'b0;
    send_block(ABC, 1'b1, 1'b1, 1'b0, 16, ok);
    n_tests++;
    if (err_timeout !== 1'b0) begin n_fail++; $display("FAIL tmo_clear: got %b exp 0", err_timeout); end
    collect_digest(0, dg, lm, ok, st);
    n_tests++;
    if (!ok || dg !== DG_ABC) begin n_fail++; $display("FAIL tmo_recover_digest: got %h exp %h", dg, DG_ABC); end
  endtask

  task automatic test_drop();
    int c0, waitc;
    bit taken;
    c0 = n_achg;
    msg_valid = 1'b1; msg_sof = 1'b0; msg_word = 32'hdeadbeef;
    waitc = 0;
    while (!msg_ready && waitc < 10) begin @(negedge clk_in); waitc++; end
    taken = msg_ready;
    @(negedge clk_in);
    msg_valid = 1'b0;
    repeat (5) @(negedge clk_in);
    n_tests++;
    if (!taken) begin n_fail++; $display("FAIL drop_accept: got no ready pulse exp pulse"); end
    n_tests++;
    if (n_achg != c0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL drop_no_cmd: got bus changes=%0d busy=%b exp 0 and 0", n_achg - c0, busy);
    end
  endtask

  task automatic test_reset_mid();
    logic [255:0] dg; logic [7:0] lm; bit ok, st;
    send_block(ABC, 1'b1, 1'b1, 1'b0, 8, ok);
    rst_in = 1'b0;
    #1;
    n_tests++;
    if ({msg_ready, dig_valid, dig_last, busy, err_timeout} !== 5'b0 || core_a_out !== 32'h0 ||
        core_d_out !== 32'h0 || dig_word !== 32'h0) begin
      n_fail++; $display("FAIL midreset_outputs: got a=%h d=%h ctrl=%b exp all 0", core_a_out, core_d_out,
                         {msg_ready, dig_valid, dig_last, busy, err_timeout});
    end
    repeat (2) @(negedge clk_in);
    rst_in = 1'b1;
    @(negedge clk_in);
    send_block(ABC, 1'b1, 1'b1, 1'b0, 16, ok);
    collect_digest(0, dg, lm, ok, st);
    n_tests++;
    if (!ok || dg !== DG_ABC) begin n_fail++; $display("FAIL midreset_digest: got %h exp %h", dg, DG_ABC); end
  endtask

  initial begin
    test_reset();
    test_abc();
    test_empty();
    test_two_block_gaps();
    test_back_to_back();
    test_timeout();
    test_drop();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got no completion exp finish within 30000 cycles");
    $fatal(1, "watchdog");
  end

endmodule
